// File: rtl/fsm_seq_gen_tx.sv
// fsm_seq_gen_tx: bit-serial framer sending preamble, MSB-first payload and guard bits
module fsm_seq_gen_tx #(
   parameter int                  SYNC_LEN = 4,
   parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011,
   parameter int                  DATA_W   = 8,
   parameter int                  GAP_LEN  = 2,
   parameter logic                IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              out,
   output logic              o_sync,
   output logic              o_done,
   output logic              o_busy
);
   localparam int MAX_SD  = SYNC_LEN > DATA_W ? SYNC_LEN : DATA_W;
   localparam int MAX_LEN = MAX_SD > GAP_LEN ? MAX_SD : GAP_LEN;
   localparam int CW      = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
   typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic [SYNC_LEN-1:0] pat, pat_n;
   logic out_n, sync_n, done_n;
   assign o_ready = (state == IDLE) & ~rst;
   assign o_busy  = state != IDLE;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      pat_n   = pat;
      unique case (state)
         IDLE: if (i_valid) begin
            state_n = SYNC;
            cnt_n   = '0;
            sh_n    = i_data;
            pat_n   = SYNC_PAT;
         end
         SYNC: if (cnt == SYNC_LAST) begin
            state_n = DATA;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + 1'b1;
            pat_n = pat << 1;
         end
         DATA: if (cnt == DATA_LAST) begin
            state_n = GAP_LEN > 0 ? GAP : IDLE;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + 1'b1;
            sh_n  = sh << 1;
         end
         GAP: if (cnt == GAP_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
         end else cnt_n = cnt + 1'b1;
      endcase
      // line outputs are registered from the next state so they line up with it
      sync_n = state_n == SYNC;
      done_n = (state_n == DATA) && (cnt_n == DATA_LAST);
      out_n  = state_n == SYNC ? pat_n[SYNC_LEN-1] : state_n == DATA ? sh_n[DATA_W-1] : IDLE_BIT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sh     <= '0;
         pat    <= '0;
         out    <= IDLE_BIT;
         o_sync <= 1'b0;
         o_done <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sh     <= sh_n;
         pat    <= pat_n;
         out    <= out_n;
         o_sync <= sync_n;
         o_done <= done_n;
      end
   end
endmodule

// File: tb/tb_fsm_seq_gen_tx.sv
// tb_fsm_seq_gen_tx: directed and random frames against a bit-list model of the frame format
module tb_fsm_seq_gen_tx;
   localparam int SL = 4;
   localparam int DW = 8;
   localparam int GL = 2;
   localparam int FL = SL + DW + GL;
   localparam int DW4 = 4;
   localparam int FL4 = SL + DW4;
   localparam logic [3:0] PAT = 4'b1011;
   logic clk = 1'b0, rst = 1'b1;
   logic i_valid = 1'b0;
   logic [7:0] i_data = '0;
   logic o_ready, out, o_sync, o_done, o_busy;
   logic v4 = 1'b0;
   logic [3:0] d4 = '0;
   logic r4, out4, s4, dn4, b4;
   int nchk = 0, nerr = 0, cyc = 0, acc = 0, prev_acc = 0, det = 0;
   logic [3:0] win = '0;
   fsm_seq_gen_tx dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .out(out), .o_sync(o_sync), .o_done(o_done), .o_busy(o_busy)
   );
   fsm_seq_gen_tx #(.DATA_W(DW4), .GAP_LEN(0)) u4 (
      .clk(clk), .rst(rst), .i_valid(v4), .i_data(d4),
      .o_ready(r4), .out(out4), .o_sync(s4), .o_done(dn4), .o_busy(b4)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // frame k-th bit: preamble MSB first, payload MSB first, then idle-level guard
   function automatic logic exp_bit(input logic [7:0] w, input int k, input int dw);
      if (k < SL) return PAT[SL-1-k];
      if (k < SL + dw) return w[dw-1-(k-SL)];
      return 1'b0;
   endfunction
   function automatic int pat_count(input logic [7:0] w);
      logic [3:0] s = '0;
      int n = 0;
      for (int k = 0; k < FL; k++) begin
         s = {s[2:0], exp_bit(w, k, DW)};
         if (s == PAT) n++;
      end
      return n;
   endfunction
   task automatic frame(input logic [7:0] w, input bit keep);
      chk("ready_pre", 32'(o_ready), 1);
      i_valid = 1'b1;
      i_data  = w;
      @(negedge clk);
      prev_acc = acc;
      acc = cyc;
      for (int k = 0; k < FL; k++) begin
         chk($sformatf("out[%0d] w=%0h", k, w), 32'(out), 32'(exp_bit(w, k, DW)));
         chk($sformatf("sync[%0d]", k), 32'(o_sync), 32'(k < SL));
         chk($sformatf("done[%0d]", k), 32'(o_done), 32'(k == SL + DW - 1));
         chk($sformatf("busy[%0d]", k), 32'(o_busy), 1);
         chk($sformatf("ready[%0d]", k), 32'(o_ready), 0);
         win = {win[2:0], out};
         if (win == PAT) det++;
         i_valid = keep;
         i_data  = 8'($urandom);
         @(negedge clk);
      end
      chk("idle_busy", 32'(o_busy), 0);
      chk("idle_ready", 32'(o_ready), 1);
      chk("idle_out", 32'(out), 0);
      chk("idle_sync", 32'(o_sync), 0);
      win = {win[2:0], out};
   endtask
   task automatic frame4(input logic [3:0] w, input bit keep);
      chk("r4_pre", 32'(r4), 1);
      v4 = 1'b1;
      d4 = w;
      @(negedge clk);
      prev_acc = acc;
      acc = cyc;
      for (int k = 0; k < FL4; k++) begin
         chk($sformatf("out4[%0d] w=%0h", k, w), 32'(out4), 32'(exp_bit({4'b0, w}, k, DW4)));
         chk($sformatf("sync4[%0d]", k), 32'(s4), 32'(k < SL));
         chk($sformatf("done4[%0d]", k), 32'(dn4), 32'(k == FL4 - 1));
         v4 = keep;
         d4 = 4'($urandom);
         @(negedge clk);
      end
      chk("idle4_out", 32'(out4), 0);
      chk("idle4_busy", 32'(b4), 0);
      chk("idle4_ready", 32'(r4), 1);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out", 32'(out), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_sync", 32'(o_sync), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_ready", 32'(o_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(o_ready), 1);
      frame(8'hA5, 1'b0);
      repeat (2) @(negedge clk);
      frame(8'hFF, 1'b1);
      frame(8'h00, 1'b0);
      chk("acc_gap_15", 32'(acc - prev_acc), 32'(FL + 1));
      // abort on the third payload bit of 0xC3
      i_valid = 1'b1;
      i_data  = 8'hC3;
      @(negedge clk);
      i_valid = 1'b0;
      for (int k = 0; k < SL + 3; k++) begin
         chk($sformatf("abort_out[%0d]", k), 32'(out), 32'(exp_bit(8'hC3, k, DW)));
         if (k < SL + 2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out", 32'(out), 0);
      chk("abort_busy", 32'(o_busy), 0);
      chk("abort_sync", 32'(o_sync), 0);
      chk("abort_done", 32'(o_done), 0);
      chk("abort_ready_rst", 32'(o_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(o_ready), 1);
      chk("abort_stays_idle", 32'(o_busy), 0);
      win = '0;
      det = 0;
      frame(8'h0B, 1'b0);
      chk("det_count", 32'(det), 32'(pat_count(8'h0B)));
      rst = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'h5A;
      @(negedge clk);
      rst = 1'b0;
      i_valid = 1'b0;
      chk("rstacc_busy", 32'(o_busy), 0);
      chk("rstacc_out", 32'(out), 0);
      @(negedge clk);
      chk("rstacc_busy2", 32'(o_busy), 0);
      chk("rstacc_out2", 32'(out), 0);
      chk("rstacc_ready", 32'(o_ready), 1);
      for (int i = 0; i < 6; i++) frame(8'($urandom), i < 5 ? 1'($urandom) : 1'b0);
      frame4(4'h9, 1'b1);
      frame4(4'($urandom), 1'b0);
      chk("acc4_gap_9", 32'(acc - prev_acc), 32'(FL4 + 1));
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
